// File: rtl/seq_eight_bit_mult.sv
// Sequential 8x8 -> 16 multiplier that time-shares one external 4x4 multiplier over four cycles.
// Optional two's-complement mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_eight_bit_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  M,
    input  logic [7:0]  Q,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        busy,
    output logic        done,
    output logic [15:0] P
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  step_q;
    logic [7:0]  ml_q;
    logic [7:0]  ql_q;
    logic [15:0] acc_q;
    logic [15:0] p_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] term_d;
    logic [15:0] acc_d;
    logic        accept_d;
    logic [7:0]  ml_d;
    logic [7:0]  ql_d;

`ifdef SEQ_MULT_SIGNED_EN
    logic        neg_q;

    // Magnitude of an 8-bit two's-complement value; -128 wraps to 0x80, which is the correct magnitude.
    function automatic logic [7:0] mag8(input logic signed [7:0] v);
        return v[7] ? 8'(~v + 8'd1) : v;
    endfunction

    function automatic logic [15:0] apply_sign(input logic [15:0] v, input logic neg);
        return neg ? 16'(~v + 16'd1) : v;
    endfunction

    assign ml_d = mag8($signed(M));
    assign ql_d = mag8($signed(Q));
`else
    assign ml_d = M;
    assign ql_d = Q;
`endif

    assign accept_d = start && (state_q != S_MUL);

    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (state_q == S_MUL) begin
            mul_a = step_q[0] ? ml_q[7:4] : ml_q[3:0];
            mul_b = step_q[1] ? ql_q[7:4] : ql_q[3:0];
        end
    end

    always_comb begin
        term_d = 16'd0;
        case (step_q)
            2'd0:    term_d = {8'd0, mul_p};
            2'd1,
            2'd2:    term_d = {4'd0, mul_p, 4'd0};
            default: term_d = {mul_p, 8'd0};
        endcase
        acc_d = acc_q + term_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            ml_q    <= 8'd0;
            ql_q    <= 8'd0;
            acc_q   <= 16'd0;
            p_q     <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_MUL: begin
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= S_DONE;
                        acc_q   <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                        p_q     <= apply_sign(acc_d, neg_q);
`else
                        p_q     <= acc_d;
`endif
                    end else begin
                        acc_q <= acc_d;
                    end
                end
                default: begin
                    // IDLE and DONE behave identically on start; DONE falls back to IDLE otherwise.
                    if (accept_d) begin
                        state_q <= S_MUL;
                        step_q  <= 2'd0;
                        ml_q    <= ml_d;
                        ql_q    <= ql_d;
                        acc_q   <= 16'd0;
                        busy_q  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_q   <= M[7] ^ Q[7];
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_seq_eight_bit_mult.sv
// Scoreboard bench for seq_eight_bit_mult; a behavioural 4x4 multiplier stands in for FourBitMult.
module tb_seq_eight_bit_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  M;
    logic [7:0]  Q;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        busy;
    logic        done;
    logic [15:0] P;

    typedef struct {
        logic [15:0] p;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_eight_bit_mult dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .M     (M),
        .Q     (Q),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pops the oldest expectation and checks value and latency.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 P=%h expected no done", P);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("P", P, e.p);
                chk("latency", 16'(cyc - e.cyc), 16'd5);
            end
        end
    end

    task automatic issue(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
        exp_t e;
        M = m;
        Q = q;
        start = 1'b1;
        e.p = exp;
        e.cyc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] exp);
        exp_t e;
        e.p = exp;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", n);
        end
    endtask

    initial begin
        logic [3:0] tr_a [4];
        logic [3:0] tr_b [4];
        tr_a = '{4'hB, 4'hA, 4'hB, 4'hA};
        tr_b = '{4'hD, 4'hD, 4'hC, 4'hC};

        rst = 1'b1;
        start = 1'b1;
        M = 8'h5A;
        Q = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_P", P, 16'h0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_mul_ab", {8'd0, mul_a, mul_b}, 16'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("no_accept_in_rst", {15'd0, busy}, 16'd0);

`ifdef SEQ_MULT_SIGNED_EN
        issue(8'h80, 8'h80, 16'h4000);
        wait_done();
        issue(8'h80, 8'h7F, 16'hC080);
        wait_done();
        issue(8'hFF, 8'h01, 16'hFFFF);
        wait_done();
        issue(8'h00, 8'h80, 16'h0000);
        wait_done();
        issue(8'hAB, 8'hCD, 16'h10EF);
        wait_done();
`else
        issue(8'hAB, 8'hCD, 16'h88EF);
        for (int i = 0; i < 4; i++) begin
            chk("trace_busy", {15'd0, busy}, 16'd1);
            chk("trace_ab", {8'd0, mul_a, mul_b}, {8'd0, tr_a[i], tr_b[i]});
            @(negedge clk);
        end
        chk("done_busy", {15'd0, busy}, 16'd0);
        chk("done_ab", {8'd0, mul_a, mul_b}, 16'd0);
        @(negedge clk);
        chk("done_pulse", {15'd0, done}, 16'd0);

        // Back-to-back with start held high through MUL and DONE.
        M = 8'hFF;
        Q = 8'hFF;
        start = 1'b1;
        push_exp(16'hFE01);
        wait_done();
        M = 8'h12;
        Q = 8'h34;
        push_exp(16'h03A8);
        wait_done();
        M = 8'h00;
        Q = 8'hFF;
        push_exp(16'h0000);
        wait_done();
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_b2b", {15'd0, busy}, 16'd0);

        issue(8'h0F, 8'h0F, 16'h00E1);
        M = 8'hFF;
        Q = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Mid-op reset at step 2: no expectation pushed, so any done is flagged.
        M = 8'h55;
        Q = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("P_stable", P, 16'h00E1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_P", P, 16'h0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_ab", {8'd0, mul_a, mul_b}, 16'd0);
        repeat (6) @(negedge clk);
        issue(8'h11, 8'h22, 16'h0242);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_eight_bit_mult.md
# seq_eight_bit_mult

Sequential 8x8 multiplier controller that time-shares a single external `FourBitMult` instance across four cycles. It splits the operands into nibbles, drives the shared 4x4 multiplier one nibble pair per cycle, and accumulates the shifted partial products into a 16-bit result. It sits beside one `FourBitMult` instance as the low-area alternative to the four-instance combinational `EightBitMult`.

## Interface
- No parameters; widths are fixed at 8x8 -> 16.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `M`  in  8  multiplicand; sampled on accept.
- `Q`  in  8  multiplier; sampled on accept.
- `mul_a`  out  4  nibble to shared `FourBitMult` M input.
- `mul_b`  out  4  nibble to shared `FourBitMult` Q input.
- `mul_p`  in  8  product from shared `FourBitMult`; combinational, same cycle as `mul_a`/`mul_b`.
- `busy`  out  1  high in the MUL state.
- `done`  out  1  one-cycle pulse; `P` is valid from this cycle onward.
- `P`  out  16  registered product; held until the next `done`.

## Operation
- State machine:
  - IDLE: `start` -> MUL, step=0.
  - MUL: step 0..3; at step 3 -> DONE.
  - DONE: `start` -> MUL, step=0; else -> IDLE.
- Accept (`start`=1 in IDLE or DONE):
  - latch `M`/`Q` into operand registers;
  - clear `acc[15:0]` to 0;
  - step=0.
- MUL drives nibbles from the latched operands only; edges of `M`/`Q` after accept are ignored.

| step | `mul_a` | `mul_b` | shift |
|---|---|---|---|
| 0 | Ml[3:0] | Ql[3:0] | 0 |
| 1 | Ml[7:4] | Ql[3:0] | 4 |
| 2 | Ml[3:0] | Ql[7:4] | 4 |
| 3 | Ml[7:4] | Ql[7:4] | 8 |

- Each MUL edge: `acc <= acc + ({8'b0, mul_p} << shift)`.
  - 16-bit unsigned add.
  - Maximum final sum is 0xFE01, so no overflow occurs.
- At the edge leaving step 3, `P` is loaded with the final sum (including the step-3 term). `P` is not updated during MUL.
- `mul_a`/`mul_b` are 0 in IDLE and DONE.
- `start` in MUL is ignored and is not queued.
- Reset has priority over every event, including reset mid-MUL:
  - state=IDLE, step=0, `acc`=0, `P`=0;
  - `done`=0, `busy`=0, `mul_a`=0, `mul_b`=0;
  - the in-flight operation is discarded and produces no `done`.

## Timing
- Reset values of all outputs are 0.
- Accept at edge E0.
- MUL occupies the cycles after edges E0..E3, with step 0..3 respectively.
- `done`=1 and the new `P` appear in the cycle after edge E4. Latency is 5 cycles from the accepting edge.
- `busy` is high for exactly 4 cycles per operation.
- `done` is high for exactly 1 cycle, unless `rst` intervenes.
- Back-to-back: `start` held high through DONE is re-accepted.
  - The next `done` arrives 5 cycles later.
  - Sustained throughput is 1 result per 5 cycles.
- `P` remains stable throughout the following operation and changes only on the edge into the next DONE.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined: `M`, `Q` and `P` are two's complement.
  - On accept, latch `|M|` and `|Q|` as 8-bit unsigned magnitudes; -128 maps to 0x80.
  - Record `neg = M[7] ^ Q[7]`.
  - The nibble sequence is unchanged and operates on the magnitudes.
  - On the edge into DONE: `P <= neg ? -acc : acc`. Zero stays 0.
- `SEQ_MULT_SIGNED_EN` undefined: everything is unsigned, no sign logic is present, and `P` equals the final `acc`.

## Test plan
- Reset: assert `rst` 2 cycles -> all outputs 0, state IDLE; `start` held during `rst` is not accepted.
- Unsigned trace: `M`=0xAB, `Q`=0xCD, `start` 1 cycle.
  - `mul_a`/`mul_b` = B/D, A/D, B/C, A/C over 4 busy cycles.
  - Then `done`=1 with `P`=0x88EF, 5 cycles after accept.
- Corners and back-to-back:
  - 0xFF x 0xFF -> `P`=0xFE01.
  - Then, with `start` held in DONE, 0x12 x 0x34 -> `P`=0x03A8, 5 cycles later.
  - Then 0x00 x 0xFF -> `P`=0x0000.
- Busy ignore and mid-op reset:
  - `start` with new operands during MUL -> no effect; result matches the original operands.
  - `rst` at step 2 -> no `done`, `P`=0; a fresh start afterwards computes correctly.
- Signed (macro on):
  - 0x80 x 0x80 -> 0x4000.
  - 0x80 x 0x7F -> 0xC080.
  - 0xFF x 0x01 -> 0xFFFF.
  - 0x00 x 0x80 -> 0x0000.
